fifo_dp_ram_ext: RTL and testbench

Parametrised synchronous FIFO built on a simple dual-port RAM, successor to the team's existing simple DP-RAM FIFO. Adds:
- a fill-level output;
- one-cycle overflow and underflow pulses;
- defined full/empty simultaneous-access rules;
- a compile-time show-ahead (first-word-fall-through) read mode.

It sits between producer and consumer blocks in the same clock domain.

---
 rtl/fifo_dp_ram_ext_pkg.sv | 20 ++
 rtl/fifo_dp_ram_ext_if.sv | 25 ++
 rtl/fifo_dp_ram_ext_dp_ram_1w1r.sv | 25 ++
 rtl/fifo_dp_ram_ext.sv | 84 ++++++++
 tb/tb_fifo_dp_ram_ext.sv | 127 ++++++++++++
 5 files changed

// File: rtl/fifo_dp_ram_ext_pkg.sv
// fifo_dp_ram_ext_pkg: shared width and flag-threshold helpers for fifo_dp_ram_ext
package fifo_dp_ram_ext_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction
  function automatic int af_level(input int depth, input int af_depth);
    return depth - af_depth;
  endfunction
  function automatic int ae_level(input int ae_depth);
    return ae_depth;
  endfunction
  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_PTR_W = ptr_w(DEFAULT_DEPTH);
endpackage

// File: rtl/fifo_dp_ram_ext_if.sv
// fifo_dp_ram_ext_if: push/pop requests, data and status of fifo_dp_ram_ext; master = producer/consumer, slave = fifo
interface fifo_dp_ram_ext_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int LEVEL_WIDTH = 6
);
  logic                   write;
  logic                   read;
  logic [DATA_WIDTH-1:0]  write_data;
  logic [DATA_WIDTH-1:0]  read_data;
  logic                   empty;
  logic                   full;
  logic                   almost_empty;
  logic                   almost_full;
  logic [LEVEL_WIDTH-1:0] level;
  logic                   overflow;
  logic                   underflow;
  modport master (
    output write, read, write_data,
    input  read_data, empty, full, almost_empty, almost_full, level, overflow, underflow
  );
  modport slave (
    input  write, read, write_data,
    output read_data, empty, full, almost_empty, almost_full, level, overflow, underflow
  );
endinterface

// File: rtl/fifo_dp_ram_ext_dp_ram_1w1r.sv
// dp_ram_1w1r: one sync write port, one enabled registered read port (read-before-write), unreset array; clk, rst, we/waddr/wdata, re/raddr/rdata
module dp_ram_1w1r
  import fifo_dp_ram_ext_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    re,
  input  logic [clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fifo_dp_ram_ext.sv
// fifo_dp_ram_ext: sync FIFO on a 1W1R RAM with level, almost flags, overflow/underflow pulses, optional show-ahead; clk, reset, bus (slave)
module fifo_dp_ram_ext
  import fifo_dp_ram_ext_pkg::*;
#(
  parameter int FIFO_DEPTH         = 32,
  parameter int FIFO_DATA_WIDTH    = 8,
  parameter int ALMOST_FULL_DEPTH  = 3,
  parameter int ALMOST_EMPTY_DEPTH = 3,
  parameter int SHOW_AHEAD         = 0
) (
  input logic              clk,
  input logic              reset,
  fifo_dp_ram_ext_if.slave bus
);
  localparam int AW = clog2(FIFO_DEPTH);
  localparam int PW = ptr_w(FIFO_DEPTH);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic empty_q, empty_d, full_q, full_d, ae_q, ae_d, af_q, af_d;
  logic ovf_q, ovf_d, unf_q, unf_d, byp_q, byp_d;
  logic [FIFO_DATA_WIDTH-1:0] byp_data_q, ram_rdata;
  logic wr_acc, rd_acc, re;
  logic [AW-1:0] raddr;
  always_comb begin
    wr_acc   = bus.write && (!full_q || bus.read);
    rd_acc   = bus.read && !empty_q;
    wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PW'(rd_acc);
    level_d  = wr_ptr_d - rd_ptr_d;
    empty_d  = wr_ptr_d == rd_ptr_d;
    full_d   = (wr_ptr_d ^ rd_ptr_d) == {1'b1, {AW{1'b0}}};
    af_d     = int'(level_d) >= af_level(FIFO_DEPTH, ALMOST_FULL_DEPTH);
    ae_d     = int'(level_d) <= ae_level(ALMOST_EMPTY_DEPTH);
    ovf_d    = bus.write && !wr_acc;
    unf_d    = bus.read && !rd_acc;
    // the next head is the slot being written this edge, so the RAM would return stale data
    byp_d    = SHOW_AHEAD != 0 && wr_acc && rd_ptr_d == wr_ptr_q;
    raddr    = SHOW_AHEAD != 0 ? rd_ptr_d[AW-1:0] : rd_ptr_q[AW-1:0];
    re       = SHOW_AHEAD != 0 || rd_acc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      byp_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      byp_q    <= byp_d;
    end
    byp_data_q <= bus.write_data;
  end
  dp_ram_1w1r #(.DEPTH(FIFO_DEPTH), .WIDTH(FIFO_DATA_WIDTH)) u_ram (
    .clk  (clk),
    .rst  (reset),
    .we   (wr_acc && !reset),
    .waddr(wr_ptr_q[AW-1:0]),
    .wdata(bus.write_data),
    .re   (re),
    .raddr(raddr),
    .rdata(ram_rdata)
  );
  assign bus.read_data    = byp_q ? byp_data_q : ram_rdata;
  assign bus.level        = level_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = ae_q;
  assign bus.almost_full  = af_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_dp_ram_ext.sv
// tb_fifo_dp_ram_ext: standard and show-ahead instances driven identically, checked against a queue model via scoreboard
module tb_fifo_dp_ram_ext;
  localparam int DEPTH = 32;
  typedef struct {
    int         level;
    bit         empty, full, ae, af, ovf, unf, chk_sa;
    logic [7:0] rd_std, rd_sa;
  } exp_t;
  logic clk, reset;
  fifo_dp_ram_ext_if #(.DATA_WIDTH(8), .LEVEL_WIDTH(6)) bus_s ();
  fifo_dp_ram_ext_if #(.DATA_WIDTH(8), .LEVEL_WIDTH(6)) bus_a ();
  fifo_dp_ram_ext #(.SHOW_AHEAD(0)) u_std (.clk(clk), .reset(reset), .bus(bus_s));
  fifo_dp_ram_ext #(.SHOW_AHEAD(1)) u_sa (.clk(clk), .reset(reset), .bus(bus_a));
  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];
  logic [7:0] mq[$];
  logic [7:0] std_rd = 0;
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model(input bit rs, input bit w, input bit r, input logic [7:0] d);
    exp_t e;
    bit wacc, racc;
    if (rs) begin
      mq.delete();
      std_rd   = 0;
      e.ovf    = 0;
      e.unf    = 0;
      e.chk_sa = 1;
      e.rd_sa  = 0;
    end else begin
      wacc = w && (mq.size() < DEPTH || r);
      racc = r && mq.size() > 0;
      if (racc) std_rd = mq.pop_front();
      if (wacc) mq.push_back(d);
      e.ovf    = w && !wacc;
      e.unf    = r && !racc;
      e.chk_sa = mq.size() > 0;
      e.rd_sa  = e.chk_sa ? mq[0] : 8'h0;
    end
    e.level  = mq.size();
    e.empty  = e.level == 0;
    e.full   = e.level == DEPTH;
    e.ae     = e.level <= 3;
    e.af     = e.level >= DEPTH - 3;
    e.rd_std = std_rd;
    exp_q.push_back(e);
  endtask
  task automatic step(input bit rs, input bit w, input bit r, input logic [7:0] d);
    reset = rs;
    bus_s.write = w; bus_s.read = r; bus_s.write_data = d;
    bus_a.write = w; bus_a.read = r; bus_a.write_data = d;
    @(posedge clk);
    model(rs, w, r, d);
    #1;
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("level_std", 32'(bus_s.level), e.level);
      chk("level_sa", 32'(bus_a.level), e.level);
      chk("empty_std", 32'(bus_s.empty), 32'(e.empty));
      chk("empty_sa", 32'(bus_a.empty), 32'(e.empty));
      chk("full_std", 32'(bus_s.full), 32'(e.full));
      chk("full_sa", 32'(bus_a.full), 32'(e.full));
      chk("aempty_std", 32'(bus_s.almost_empty), 32'(e.ae));
      chk("aempty_sa", 32'(bus_a.almost_empty), 32'(e.ae));
      chk("afull_std", 32'(bus_s.almost_full), 32'(e.af));
      chk("afull_sa", 32'(bus_a.almost_full), 32'(e.af));
      chk("overflow_std", 32'(bus_s.overflow), 32'(e.ovf));
      chk("overflow_sa", 32'(bus_a.overflow), 32'(e.ovf));
      chk("underflow_std", 32'(bus_s.underflow), 32'(e.unf));
      chk("underflow_sa", 32'(bus_a.underflow), 32'(e.unf));
      chk("rdata_std", 32'(bus_s.read_data), 32'(e.rd_std));
      if (e.chk_sa) chk("rdata_sa", 32'(bus_a.read_data), 32'(e.rd_sa));
    end
  end
  initial begin
    reset = 1;
    bus_s.write = 0; bus_s.read = 0; bus_s.write_data = 0;
    bus_a.write = 0; bus_a.read = 0; bus_a.write_data = 0;
    step(1, 0, 0, 0);
    step(1, 1, 1, 8'h11);
    for (int i = 0; i < 40; i++) begin step(0, 1, 0, 8'(i)); step(0, 0, 0, 0); end
    for (int i = 0; i < 40; i++) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
    for (int i = 32; i < 72; i++) begin step(0, 1, 0, 8'(i)); step(0, 0, 0, 0); end
    for (int i = 0; i < 40; i++) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
    for (int i = 64; i < 67; i++) step(0, 1, 0, 8'(i));
    for (int i = 0; i < 67; i++) step(0, 1, 1, 8'(67 + i));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    step(0, 1, 1, 8'h80);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 8'hA5);
    step(0, 0, 0, 0);
    step(0, 1, 0, 8'h5A);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 8'h33);
    step(1, 1, 0, 8'h44);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      wp = ((i / 250) % 4 == 0) ? 80 : ((i / 250) % 4 == 1) ? 20 : 55;
      rp = ((i / 250) % 4 == 1) ? 80 : ((i / 250) % 4 == 0) ? 20 : 50;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < wp,
           $urandom_range(0, 99) < rp, 8'($urandom));
    end
    step(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
